sobel_frame_sequencer: RTL and testbench
========================================

# sobel_frame_sequencer

Frame-level controller for the Sobel convolution datapath. It sits between the camera FIFO and the line-buffer/kernel pipeline. It paces pixel reads against output-FIFO fill, tracks column/row position, and rotates the three line-buffer banks at each line end. It also flags which accepted pixels complete a full 3x3 window, so the downstream pipeline writes only interior edge results to the output FIFO.

## Interface
Parameters:
- H_ACTIVE, 640: pixels per line (≥3).
- V_ACTIVE, 480: lines per frame (≥3).
- FIFO_AW, 10: output-FIFO count width.
- HIGH_WM, 896: output-FIFO count at or above which reads stop.
- LOW_WM, 768: output-FIFO count at or below which reads resume (LOW_WM < HIGH_WM).
- WDT_CYCLES, 65535: idle-input timeout, used only with SOBEL_SEQ_WDT_EN.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- frame_start, input, 1: one-cycle pulse that begins a frame.
- data_available, input, 1: camera FIFO holds a pixel.
- fifo_count, input, FIFO_AW: output-FIFO occupancy.
- rd_en, output, 1: pop camera FIFO; this is the accept strobe.
- pix_valid, output, 1: registered; the other position outputs describe the pixel accepted last cycle.
- col, output, 10: column of that pixel.
- row, output, 9: row of that pixel.
- wr_bank, output, 2: line-buffer bank being written (0..2).
- top_bank, output, 2: oldest line's bank, equal to (wr_bank+1) mod 3.
- mid_bank, output, 2: middle line's bank, equal to (wr_bank+2) mod 3.
- win_valid, output, 1: the pixel completes a 3x3 window centred at (row-1, col-1).
- sof, output, 1: start-of-frame qualifier on pix_valid.
- eol, output, 1: end-of-line qualifier on pix_valid.
- eof, output, 1: end-of-frame qualifier on pix_valid.
- hold, output, 1: backpressure active.
- busy, output, 1: state ≠ IDLE.
- err_resync, output, 1: one-cycle pulse.
- err_timeout, output, 1: one-cycle pulse.

## Operation
State machine has three states:
- IDLE: rd_en=0. On frame_start, go to PRIME with counters cleared and wr_bank=0.
- PRIME: accepts rows 0..1. These only fill the line buffers, so win_valid=0. Moves to RUN on the accept of (col=H_ACTIVE-1, row=1).
- RUN: accepts rows 2..V_ACTIVE-1. Returns to IDLE on the accept of (H_ACTIVE-1, V_ACTIVE-1).

Accept rule:
- rd_en = data_available & (state ∈ {PRIME, RUN}) & !hold & !rst. It is combinational.
- Each rd_en=1 cycle consumes exactly one pixel.

Position and bank tracking:
- col increments per accept and wraps to 0 after H_ACTIVE-1.
- row increments on that wrap.
- wr_bank advances mod 3 on that wrap.

Output flags:
- win_valid = (row≥2) & (col≥2), computed on the accepted pixel.
- sof = (row=0 & col=0).
- eol = (col=H_ACTIVE-1).
- eof = eol & (row=V_ACTIVE-1).

Backpressure (hysteresis):
- hold sets on the clock edge when fifo_count ≥ HIGH_WM.
- hold clears when fifo_count ≤ LOW_WM.
- Otherwise hold keeps its value.
- hold is evaluated in every state.

Resync:
- frame_start while busy aborts the current frame.
- State goes to PRIME, counters and wr_bank are cleared, and err_resync pulses.
- No pixel is accepted in that cycle.
- frame_start in the same cycle as the final eof accept is taken as a new frame, with no err_resync.

## Timing
Reset values:
- All registered outputs are 0, state is IDLE, hold=0.
- rd_en is forced 0 while rst=1.

Latency:
- pix_valid and all position/bank/flag outputs are valid exactly 1 cycle after the rd_en cycle.
- The bank outputs reflect the bank of the accepted pixel, not the post-wrap value.

Backpressure:
- fifo_count → hold → rd_en has 1-cycle lag.
- Integrator guarantees HIGH_WM ≤ 2^FIFO_AW − 4.

Frame boundaries:
- State change on the final accept takes effect on the next edge.
- A data_available held high after the final accept produces no further rd_en until the next frame_start.

Reset:
- Mid-frame reset discards position.
- The first post-reset frame requires a new frame_start.

## Configuration
- SOBEL_SEQ_WDT_EN defined: a counter clears on every accept and on state entry. It increments each cycle in PRIME/RUN while no accept occurs, including during hold. When it reaches WDT_CYCLES:
  - the block goes to IDLE;
  - err_timeout pulses for 1 cycle;
  - the counter clears.
- SOBEL_SEQ_WDT_EN undefined: no counter, and err_timeout is tied 0.

## Test plan
Benches use H_ACTIVE=8, V_ACTIVE=4, HIGH_WM=6, LOW_WM=3, and WDT_CYCLES=16.
- Full frame, data_available=1, fifo_count=0 → 32 consecutive rd_en.
  - pix_valid pulses = 32.
  - win_valid pulses = 12 (rows 2..3, cols 2..7).
  - wr_bank sequence per line is 0,1,2,0.
  - eof on the 32nd pix_valid; busy drops the cycle after it.
- fifo_count raised to 6 mid-RUN → hold=1 one cycle later and rd_en=0 from the following cycle. fifo_count 5 or 4 keeps hold=1. fifo_count 3 → hold=0 and reads resume with col continuous and no pixel skipped.
- frame_start at pixel 13 → err_resync pulses 1 cycle. The next pix_valid shows sof, row=0, col=0, wr_bank=0.
- rst asserted at pixel 20 → same-cycle rd_en=0. All outputs are 0 next cycle. data_available=1 without frame_start gives no rd_en.
- data_available=0 for 16 cycles in RUN → with WDT_EN, err_timeout pulses on cycle 16 and busy=0. Without WDT_EN, busy stays 1 and err_timeout stays 0.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// Frame controller for the Sobel datapath: paces camera reads, tracks position, rotates line banks.
// Optional idle-input watchdog enabled with `define SOBEL_SEQ_WDT_EN.
//
// state | meaning
// IDLE  | waiting for frame_start, no reads
// PRIME | filling line buffers with rows 0..1
// RUN   | rows 2..V_ACTIVE-1, windows complete
module sobel_frame_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_AW    = 10,
    parameter int HIGH_WM    = 896,
    parameter int LOW_WM     = 768,
    parameter int WDT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               data_available,
    input  logic [FIFO_AW-1:0] fifo_count,
    output logic               rd_en,
    output logic               pix_valid,
    output logic [9:0]         col,
    output logic [8:0]         row,
    output logic [1:0]         wr_bank,
    output logic [1:0]         top_bank,
    output logic [1:0]         mid_bank,
    output logic               win_valid,
    output logic               sof,
    output logic               eol,
    output logic               eof,
    output logic               hold,
    output logic               busy,
    output logic               err_resync,
    output logic               err_timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    localparam logic [9:0]         COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0]         ROW_LAST = 9'(V_ACTIVE - 1);
    localparam logic [FIFO_AW-1:0] HIGH     = FIFO_AW'(HIGH_WM);
    localparam logic [FIFO_AW-1:0] LOW      = FIFO_AW'(LOW_WM);

    state_t     state, state_next;
    logic [9:0] col_cnt;
    logic [8:0] row_cnt;
    logic [1:0] bank;
    logic       line_end, at_last;
    logic       clr_pos, resync, timeout, wdt_expire;

    assign busy     = (state != IDLE);
    assign line_end = (col_cnt == COL_LAST);
    assign at_last  = (state == RUN) && line_end && (row_cnt == ROW_LAST);
    // A frame_start coinciding with the final pixel starts a new frame, so that pixel is still taken.
    assign rd_en    = data_available && busy && !hold && !rst && !(frame_start && !at_last);

    always_comb begin
        state_next = state;
        clr_pos    = 1'b0;
        resync     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = PRIME;
                    clr_pos    = 1'b1;
                end
            end
            PRIME, RUN: begin
                if (frame_start) begin
                    state_next = PRIME;
                    clr_pos    = 1'b1;
                    resync     = !(rd_en && at_last);
                end else if (rd_en && at_last) begin
                    state_next = IDLE;
                end else if (state == PRIME && rd_en && line_end && row_cnt == 9'd1) begin
                    state_next = RUN;
                end else if (wdt_expire) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_pos) begin
            col_cnt <= '0;
            row_cnt <= '0;
            bank    <= '0;
        end else if (rd_en) begin
            if (line_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 9'd1;
                bank    <= (bank == 2'd2) ? 2'd0 : bank + 2'd1;
            end else begin
                col_cnt <= col_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= 1'b0;
        end else if (fifo_count >= HIGH) begin
            hold <= 1'b1;
        end else if (fifo_count <= LOW) begin
            hold <= 1'b0;
        end
    end

    // Position outputs describe the pixel accepted last cycle; bank is the pre-wrap value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            col        <= '0;
            row        <= '0;
            wr_bank    <= '0;
            top_bank   <= '0;
            mid_bank   <= '0;
            win_valid  <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            err_resync <= 1'b0;
        end else begin
            pix_valid  <= rd_en;
            err_resync <= resync;
            win_valid  <= rd_en && (row_cnt >= 9'd2) && (col_cnt >= 10'd2);
            sof        <= rd_en && (row_cnt == 9'd0) && (col_cnt == 10'd0);
            eol        <= rd_en && line_end;
            eof        <= rd_en && line_end && (row_cnt == ROW_LAST);
            if (rd_en) begin
                col      <= col_cnt;
                row      <= row_cnt;
                wr_bank  <= bank;
                top_bank <= (bank == 2'd2) ? 2'd0 : bank + 2'd1;
                mid_bank <= (bank == 2'd0) ? 2'd2 : bank - 2'd1;
            end
        end
    end

`ifdef SOBEL_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_expire = busy && !rd_en && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || rd_en || clr_pos || (state_next != state)) wdt_cnt <= '0;
        else if (busy)                                         wdt_cnt <= wdt_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_timeout <= 1'b0;
        else     err_timeout <= timeout;
    end
`else
    logic unused_wdt;
    assign wdt_expire  = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_wdt  = ^{WDT_CYCLES, timeout};
`endif

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer: frame-index reference model predicts reads and pixels,
// a separate monitor checks registered pixel outputs. Honors SOBEL_SEQ_WDT_EN for timeout expectations.
module tb_sobel_frame_sequencer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;

    logic       clk = 1'b0;
    logic       rst, frame_start, data_available;
    logic [9:0] fifo_count;
    logic       rd_en, pix_valid, win_valid, sof, eol, eof, hold, busy, err_resync, err_timeout;
    logic [9:0] col;
    logic [8:0] row;
    logic [1:0] wr_bank, top_bank, mid_bank;

    sobel_frame_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_AW(10), .HIGH_WM(6), .LOW_WM(3), .WDT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .data_available(data_available),
        .fifo_count(fifo_count), .rd_en(rd_en), .pix_valid(pix_valid), .col(col), .row(row),
        .wr_bank(wr_bank), .top_bank(top_bank), .mid_bank(mid_bank), .win_valid(win_valid),
        .sof(sof), .eol(eol), .eof(eof), .hold(hold), .busy(busy),
        .err_resync(err_resync), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c; int r; int bank; int win; int sof; int eol; int eof;
    } pix_t;

    pix_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pv_cnt = 0;
    int   win_cnt = 0;

    bit m_active = 0;
    bit m_hold = 0;
    bit m_resync = 0;
    bit m_timeout = 0;
    int m_k = 0;
    int m_idle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic pix_t expect_pix(input int k);
        pix_t p;
        p.c    = k % H;
        p.r    = k / H;
        p.bank = (k / H) % 3;
        p.win  = (p.r >= 2 && p.c >= 2) ? 1 : 0;
        p.sof  = (k == 0) ? 1 : 0;
        p.eol  = (p.c == H - 1) ? 1 : 0;
        p.eof  = (k == N - 1) ? 1 : 0;
        return p;
    endfunction

    // Reference model: inputs are stable at the falling edge; predict the coming rising edge.
    always @(negedge clk) begin
        bit exp_rd, last;
        last   = m_active && (m_k == N - 1);
        exp_rd = data_available && m_active && !m_hold && !rst && !(frame_start && !last);
        chk("rd_en", rd_en, exp_rd);
        chk("busy", busy, m_active);
        chk("hold", hold, m_hold);
        chk("err_resync", err_resync, m_resync);
        chk("err_timeout", err_timeout, m_timeout);
        if (rst) begin
            m_active = 0; m_hold = 0; m_resync = 0; m_timeout = 0; m_k = 0; m_idle = 0;
        end else begin
            m_resync  = m_active && frame_start && !(exp_rd && last);
            m_timeout = 0;
            if (exp_rd) q.push_back(expect_pix(m_k));
            if (frame_start) begin
                m_active = 1; m_k = 0; m_idle = 0;
            end else if (exp_rd) begin
                m_k++;
                m_idle = 0;
                if (m_k == N) m_active = 0;
            end else if (m_active) begin
                m_idle++;
`ifdef SOBEL_SEQ_WDT_EN
                if (m_idle == 16) begin
                    m_active = 0; m_timeout = 1; m_idle = 0;
                end
`endif
            end
            if (fifo_count >= 6) m_hold = 1;
            else if (fifo_count <= 3) m_hold = 0;
        end
    end

    always @(negedge clk) begin
        pix_t p;
        if (pix_valid) begin
            pv_cnt++;
            win_cnt += int'(win_valid);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pix_unexpected actual=1 expected=0 t=%0t", $time);
            end else begin
                p = q.pop_front();
                chk("col", col, p.c);
                chk("row", row, p.r);
                chk("wr_bank", wr_bank, p.bank);
                chk("top_bank", top_bank, (p.bank + 1) % 3);
                chk("mid_bank", mid_bank, (p.bank + 2) % 3);
                chk("win_valid", win_valid, p.win);
                chk("sof", sof, p.sof);
                chk("eol", eol, p.eol);
                chk("eof", eof, p.eof);
            end
        end
    end

    task automatic drive(input bit r, input bit f, input bit d, input int c, input int n);
        rst = r; frame_start = f; data_available = d; fifo_count = 10'(c);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_wr_bank"}, wr_bank, 0);
        chk({tag, "_top_bank"}, top_bank, 0);
        chk({tag, "_mid_bank"}, mid_bank, 0);
        chk({tag, "_flags"}, {win_valid, sof, eol, eof}, 0);
        chk({tag, "_hold"}, hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_bound", busy, 0);
    endtask

    initial begin
        int c;
        drive(1, 0, 0, 0, 3);
        check_zero("reset");
        drive(0, 0, 1, 0, 2);

        // full frame, no backpressure
        pv_cnt = 0; win_cnt = 0;
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 32);
        drive(0, 0, 1, 0, 3);
        chk("frame_pix_count", pv_cnt, 32);
        chk("frame_win_count", win_cnt, 12);

        // hysteresis backpressure mid-RUN
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 20);
        drive(0, 0, 1, 6, 1);
        drive(0, 0, 1, 5, 2);
        drive(0, 0, 1, 4, 2);
        chk("hold_kept", hold, 1);
        drive(0, 0, 1, 3, 1);
        drive(0, 0, 1, 0, 1);
        wait_idle(100);

        // resync at pixel 13
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 13);
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        wait_idle(100);

        // frame_start together with the final accept
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 31);
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        wait_idle(100);

        // mid-frame reset
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 20);
        drive(1, 0, 1, 0, 1);
        check_zero("midrst");
        drive(0, 0, 1, 0, 5);

        // input starvation in RUN
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 20);
        drive(0, 0, 0, 0, 20);
        drive(0, 0, 1, 0, 1);
        wait_idle(100);

        // randomized traffic
        c = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) c = (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 8)));
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) < 8), c, 1);
        end
        drive(0, 0, 0, 0, 3);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
